dmac_mc_locked: RTL and testbench

Multi-channel DMA transfer controller. It is the parametrised successor of the single-channel dmac FSM benchmark in the locked-benchmark set. NCH requesters are served round-robin, and each is moved word-by-word over a req/ack bus handshake. A KEY_W-bit key gates a duplicated read state: the correct key gives functional behaviour, while a wrong key routes through a decoy state that corrupts transfers after DECOY_LIMIT words.

---
 rtl/dmac_pkg.sv | 34 +++
 rtl/dmac_rr_arbiter.sv | 32 +++
 rtl/dmac_mc_locked.sv | 116 +++++++++++
 tb/tb_dmac_mc_locked.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared state encoding, width helper and ch_len slice extraction for the locked DMA controller
package dmac_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARB     = 3'd1,
    S_REQ_BUS = 3'd2,
    S_READ    = 3'd3,
    S_READ_D  = 3'd4,
    S_WRITE   = 3'd5,
    S_NEXT    = 3'd6,
    S_DONE    = 3'd7
  } dmac_state_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  localparam int DEF_NCH   = 4;
  localparam int CH_W      = clog2_min1(DEF_NCH);
  localparam int LEN_BUS_W = 256;

  // Callers zero-extend the packed ch_len bus to LEN_BUS_W so one function serves every NCH/CNT_W.
  function automatic logic [31:0] len_slice(input logic [LEN_BUS_W-1:0] bus, input int i, input int w);
    logic [LEN_BUS_W-1:0] sh;
    logic [31:0]          m;
    sh = bus >> (i * w);
    m  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return sh[31:0] & m;
  endfunction

endpackage

// File: rtl/dmac_rr_arbiter.sv
// rtl/dmac_rr_arbiter.sv - combinational round-robin pick of the first requester after the pointer
module dmac_rr_arbiter
  import dmac_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]               req,
  input  logic [clog2_min1(NCH)-1:0]   ptr,
  output logic [clog2_min1(NCH)-1:0]   grant,
  output logic                         any_req
);

  localparam int W = clog2_min1(NCH);

  logic         found;
  logic [W-1:0] idx;

  always_comb begin
    grant   = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = W'((int'(ptr) + k) % NCH);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmac_mc_locked.sv
// rtl/dmac_mc_locked.sv - key-locked multi-channel DMA controller FSM, falling-edge state, Moore outputs
module dmac_mc_locked
  import dmac_pkg::*;
#(
  parameter int               NCH         = 4,
  parameter int               CNT_W       = 8,
  parameter int               KEY_W       = 8,
  parameter logic [KEY_W-1:0] KEY_VALUE   = 8'hA5,
  parameter int               DECOY_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             ch_req,
  input  logic [NCH*CNT_W-1:0]       ch_len,
  input  logic                       bus_gnt,
  input  logic                       xfer_ack,
  input  logic [KEY_W-1:0]           key,
  output logic                       bus_req,
  output logic                       rd_stb,
  output logic                       wr_stb,
  output logic [clog2_min1(NCH)-1:0] ch_sel,
  output logic [NCH-1:0]             ch_done,
  output logic                       busy,
  output logic                       err
);

  localparam int SEL_W = clog2_min1(NCH);

  dmac_state_t        state, state_nx;
  logic [SEL_W-1:0]   rr_ptr, sel_q, grant;
  logic [CNT_W-1:0]   cnt, len_sel;
  logic [7:0]         decoy_cnt;
  logic               key_ok, err_q, any_req, decoy_hit;

  dmac_rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (ch_req),
    .ptr     (rr_ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  assign len_sel   = CNT_W'(len_slice(LEN_BUS_W'(ch_len), int'(grant), CNT_W));
  assign decoy_hit = (decoy_cnt == 8'(DECOY_LIMIT));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (|ch_req) state_nx = S_ARB;
      S_ARB: begin
        if (!any_req)            state_nx = S_IDLE;
        else if (len_sel == '0)  state_nx = S_DONE;
        else                     state_nx = S_REQ_BUS;
      end
      S_REQ_BUS: if (bus_gnt) state_nx = key_ok ? S_READ : S_READ_D;
      S_READ:    if (xfer_ack) state_nx = S_WRITE;
      // Once the decoy budget is spent the read phase is skipped without waiting for ack.
      S_READ_D:  if (decoy_hit || xfer_ack) state_nx = S_WRITE;
      S_WRITE:   if (xfer_ack) state_nx = S_NEXT;
      S_NEXT:    state_nx = (cnt == CNT_W'(1)) ? S_DONE : (key_ok ? S_READ : S_READ_D);
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= SEL_W'(NCH - 1);
      sel_q     <= '0;
      cnt       <= '0;
      decoy_cnt <= '0;
      key_ok    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_ARB && any_req) begin
        sel_q  <= grant;
        rr_ptr <= grant;
        cnt    <= len_sel;
        key_ok <= (key == KEY_VALUE);
      end
      if (state == S_READ_D && !decoy_hit && xfer_ack) decoy_cnt <= decoy_cnt + 8'd1;
      if (state == S_NEXT) cnt <= cnt - CNT_W'(1);
      if (xfer_ack && (state == S_IDLE || state == S_ARB || state == S_DONE)) err_q <= 1'b1;
    end
  end

  always_comb begin
    bus_req = 1'b0;
    rd_stb  = 1'b0;
    wr_stb  = 1'b0;
    ch_done = '0;
    case (state)
      S_REQ_BUS, S_NEXT: bus_req = 1'b1;
      S_READ: begin
        bus_req = 1'b1;
        rd_stb  = 1'b1;
      end
      S_READ_D: begin
        bus_req = 1'b1;
        rd_stb  = !decoy_hit;
      end
      S_WRITE: begin
        bus_req = 1'b1;
        wr_stb  = 1'b1;
      end
      S_DONE:  ch_done[sel_q] = 1'b1;
      default: ;
    endcase
  end

  assign busy   = (state != S_IDLE);
  assign ch_sel = sel_q;
  assign err    = err_q;

endmodule

// File: tb/tb_dmac_mc_locked.sv
// tb/tb_dmac_mc_locked.sv - directed self-checking bench for dmac_mc_locked
module tb_dmac_mc_locked;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_req;
  logic [31:0] ch_len;
  logic        bus_gnt, xfer_ack;
  logic [7:0]  key;
  logic        bus_req, rd_stb, wr_stb, busy, err;
  logic [1:0]  ch_sel;
  logic [3:0]  ch_done;

  int tests = 0, fails = 0;
  int rd_n, wr_n, breq_n, done_n;
  int done_q[$];
  logic ack_en, gnt_en, force_ack, hold;

  dmac_mc_locked dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_len(ch_len), .bus_gnt(bus_gnt),
    .xfer_ack(xfer_ack), .key(key), .bus_req(bus_req), .rd_stb(rd_stb), .wr_stb(wr_stb),
    .ch_sel(ch_sel), .ch_done(ch_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // State moves on the falling edge, so outputs are sampled and inputs driven on the rising edge.
  task automatic tick();
    @(posedge clk);
    rd_n   += int'(rd_stb);
    wr_n   += int'(wr_stb);
    breq_n += int'(bus_req);
    if (ch_done != 4'b0) begin
      done_n++;
      done_q.push_back(int'(ch_sel));
      check("done_onehot", 32'(ch_done), 32'(4'b0001 << ch_sel));
      if (!hold) ch_req = ch_req & ~ch_done;
    end
    xfer_ack = force_ack | (ack_en & bus_req);
    bus_gnt  = gnt_en & bus_req;
  endtask

  task automatic clear_counts();
    rd_n = 0; wr_n = 0; breq_n = 0; done_n = 0;
    done_q.delete();
  endtask

  task automatic run_until(input int ndone, input int budget);
    int c;
    c = 0;
    while (done_n < ndone && c < budget) begin
      tick();
      c++;
    end
    check("done_within_budget", 32'(done_n >= ndone), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_req = 4'b0; xfer_ack = 1'b0; bus_gnt = 1'b0;
    force_ack = 1'b0; hold = 1'b0; ack_en = 1'b1; gnt_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    rst = 1'b0;
    clear_counts();
  endtask

  initial begin
    int c;
    ch_len = 32'h0; key = 8'hA5;
    do_reset();
    rst = 1'b1;
    #1;
    check("reset_outputs", 32'({bus_req, rd_stb, wr_stb, busy, err, ch_sel, ch_done}), 32'd0);

    // Correct key, ch0 len=2
    do_reset();
    key = 8'hA5; ch_len = {8'd0, 8'd0, 8'd0, 8'd2}; ch_req = 4'b0001;
    run_until(1, 100);
    check("t1_rd", rd_n, 2);
    check("t1_wr", wr_n, 2);
    check("t1_sel", done_q[0], 0);
    repeat (3) tick();
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_single_done", done_n, 1);

    // Round robin across four held requests
    do_reset();
    ch_len = {8'd1, 8'd1, 8'd1, 8'd1}; ch_req = 4'b1111; hold = 1'b1;
    run_until(5, 300);
    ch_req = 4'b0; hold = 1'b0;
    for (int i = 0; i < 5; i++) check($sformatf("t2_order%0d", i), done_q[i], i % 4);

    // Wrong key: 4 real reads, then silent corruption
    do_reset();
    key = 8'h00; ch_len = {8'd0, 8'd0, 8'd6, 8'd0}; ch_req = 4'b0010;
    run_until(1, 200);
    check("t3_rd", rd_n, 4);
    check("t3_wr", wr_n, 6);
    check("t3_sel", done_q[0], 1);
    repeat (2) tick();
    clear_counts();
    ch_len = {8'd0, 8'd0, 8'd2, 8'd0}; ch_req = 4'b0010;
    run_until(1, 100);
    check("t3b_rd", rd_n, 0);
    check("t3b_wr", wr_n, 2);

    // Zero-length transfer
    do_reset();
    key = 8'hA5; ch_len = {8'd3, 8'd0, 8'd3, 8'd3}; ch_req = 4'b0100;
    run_until(1, 50);
    check("t4_sel", done_q[0], 2);
    check("t4_no_bus", breq_n + rd_n + wr_n, 0);

    // Reset during WRITE of word 3 (wrong key so decoy progress is observable)
    do_reset();
    key = 8'h00; ch_len = {8'd0, 8'd0, 8'd0, 8'd5}; ch_req = 4'b0001;
    c = 0;
    while (wr_n < 3 && c < 200) begin
      tick();
      c++;
    end
    check("t5_reach_write3", wr_n, 3);
    rst = 1'b1;
    #1;
    check("t5_async_clear", 32'({bus_req, rd_stb, wr_stb, busy, ch_done}), 32'd0);
    check("t5_no_done", done_n, 0);
    ch_req = 4'b0; xfer_ack = 1'b0; bus_gnt = 1'b0;
    @(posedge clk);
    rst = 1'b0;
    clear_counts();
    ch_len = {8'd1, 8'd0, 8'd0, 8'd4}; ch_req = 4'b1001;
    run_until(1, 200);
    check("t5_ch0_first", done_q[0], 0);
    check("t5_decoy_restart", rd_n, 4);

    // Protocol error is sticky until reset
    do_reset();
    check("t6_err_clear", 32'(err), 32'd0);
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    tick();
    check("t6_err_set", 32'(err), 32'd1);
    key = 8'hA5; ch_len = {8'd0, 8'd0, 8'd0, 8'd1}; ch_req = 4'b0001;
    run_until(1, 100);
    repeat (2) tick();
    check("t6_err_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_err_reset", 32'(err), 32'd0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
